tx_sched: RTL
=============

# tx_sched

Transmit scheduler for the VLC sync transmitter. Sequences `tx_loop`, sharing it between a periodic beacon source and host data-frame requests. Issues a one-cycle start with a frame-kind select, waits for the frame-end indication, and enforces a guard gap between frames. Sits between the host/control logic and `tx_loop` on the same clock domain.

## Interface
Parameters:
- `PERIOD_W`, 16: width of the beacon period input.
- `GUARD`, 8: idle cycles inserted after each frame (≥1).
- `TIMEOUT`, 1024: maximum cycles waited for `i_tx_ind` after a start.

Ports:
- `clk`  in  1  sole clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `i_enable`  in  1  scheduler enable; low blocks new frames.
- `i_period`  in  PERIOD_W  beacon interval in cycles; 0 disables beacons.
- `i_req`  in  1  host data-frame request, level, held until `o_grant`.
- `o_grant`  out  1  one-cycle pulse: data request accepted.
- `o_tx_start`  out  1  one-cycle start pulse to `tx_loop`.
- `o_tx_kind`  out  1  0 = beacon, 1 = data; valid with and held after `o_tx_start` until return to IDLE.
- `i_tx_ind`  in  1  frame-end indication from `tx_loop`.
- `o_busy`  out  1  high in every state except IDLE.
- `o_seq`  out  8  beacon sequence number, increments on each beacon start, wraps 255→0.
- `o_overrun`  out  1  sticky: beacon fell due while one was already pending.
- `o_timeout`  out  1  sticky: `TIMEOUT` reached in WAIT.

## Operation
- Reset (`reset`=0 at an edge): state IDLE, all outputs 0, beacon timer loaded with `i_period`-1, pending flag cleared, stickies cleared. Mid-frame reset aborts immediately; `tx_loop` shares the reset.
- Beacon timer: counts down while `i_enable`=1 and `i_period`≠0; at 0 sets `beacon_pend` and reloads `i_period`-1. If `beacon_pend` is already set, it sets `o_overrun` (pending stays 1, no queueing). `i_enable`=0 holds the timer at reload value. A `i_period` change takes effect at next reload.
- FSM states: IDLE, START, WAIT, GAP.
  - IDLE: if `i_enable` and `beacon_pend` → START, kind=0. Else if `i_enable` and `i_req` → START, kind=1. Beacon wins when both present.
  - START (1 cycle): `o_tx_start`=1; beacon: clear `beacon_pend`, `o_seq`++ ; data: `o_grant`=1. → WAIT.
  - WAIT: `i_tx_ind`=1 → GAP. Wait counter reaches `TIMEOUT` → set `o_timeout`, → GAP. `i_tx_ind` in the START cycle is ignored.
  - GAP: count `GUARD` cycles, then → IDLE.
- `i_enable` falling mid-frame: current frame finishes normally; no new start.
- Beacon falling due during START/WAIT/GAP: held pending, served at the next IDLE.

## Timing
- Request/pending seen in IDLE at edge n → `o_tx_start` high in cycle n+1.
- `i_tx_ind` seen at edge m in WAIT → GAP from m+1; IDLE re-entered GUARD cycles later; earliest next start is 1 cycle after IDLE entry.
- Minimum frame spacing start-to-start: 1 + (WAIT length) + GUARD + 1 cycles.
- All outputs registered; no combinational input→output paths.

## Structure
- Package `tx_sched_pkg`: FSM state encoding, `KIND_BEACON`/`KIND_DATA` constants, `SEQ_W`=8.
- Sub-module `beacon_timer`: down-counter, reload, `beacon_pend`, overrun logic; inputs enable/period/clear, outputs pending/overrun.
- Top: FSM, wait/guard counter (shared, width from max(TIMEOUT,GUARD)), sequence counter.

## Test plan
- Single data frame: `i_period`=0, raise `i_req`, `i_tx_ind` 20 cycles after start → one `o_grant`+`o_tx_start`(kind 1) cycle, `o_busy` falls 8 cycles after `i_tx_ind`.
- Periodic beacons: `i_period`=100, tx_loop model ends frames after 30 cycles → starts every 100 cycles, kind 0, `o_seq` 0,1,2…, wraps 255→0 after 256 beacons.
- Contention: beacon due and `i_req` high in the same IDLE cycle → beacon first, data granted after its GAP; no lost request.
- Overrun: `i_period`=10, frames last 40 cycles → `o_overrun` sets and stays 1 until reset; exactly one beacon per IDLE entry.
- Timeout: never assert `i_tx_ind` → `o_timeout`=1 after 1024 WAIT cycles, FSM passes GAP to IDLE, next request served.
- Reset mid-WAIT: `reset`=0 for one edge → next cycle all outputs 0, state IDLE, timer reloaded, stickies cleared.

Source files
------------

// File: rtl/tx_sched_pkg.sv
// Shared constants for the transmit scheduler: FSM encoding, frame kinds,
// and the beacon sequence-number width.
package tx_sched_pkg;

  localparam int SEQ_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam logic KIND_BEACON = 1'b0;
  localparam logic KIND_DATA   = 1'b1;

endpackage

// File: rtl/tx_sched_beacon_timer.sv
// Beacon interval timer: down-counts the period, raises a pending flag when
// a beacon falls due and records an overrun when one is already waiting.
module beacon_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic                clear,
  output logic                pending,
  output logic                overrun
);

  localparam logic [PERIOD_W-1:0] ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

  logic [PERIOD_W-1:0] cnt;
  logic                due;
  logic                pend_kept;

  // A beacon is due when the running counter has expired; a pending flag
  // that is being served this cycle does not count towards an overrun.
  assign due       = enable && (period != '0) && (cnt == '0);
  assign pend_kept = pending && !clear;

  // Counter reload/hold, pending flag and sticky overrun.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= period - ONE;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (!enable || (period == '0) || due) begin
        cnt <= period - ONE;
      end else begin
        cnt <= cnt - ONE;
      end
      pending <= due || pend_kept;
      if (due && pend_kept) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_sched.sv
// Transmit scheduler: shares tx_loop between periodic beacons and host data
// frames, issuing a one-cycle start, waiting for frame end (with timeout) and
// inserting a guard gap before the next frame.
module tx_sched
  import tx_sched_pkg::*;
#(
  parameter int PERIOD_W = 16,
  parameter int GUARD    = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_enable,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_req,
  output logic                o_grant,
  output logic                o_tx_start,
  output logic                o_tx_kind,
  input  logic                i_tx_ind,
  output logic                o_busy,
  output logic [SEQ_W-1:0]    o_seq,
  output logic                o_overrun,
  output logic                o_timeout
);

  // One counter serves both the WAIT timeout and the GAP guard interval.
  localparam int CNT_MAX = (TIMEOUT > GUARD) ? TIMEOUT : GUARD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [SEQ_W-1:0] SEQ_ONE      = SEQ_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             beacon_pend;
  logic             beacon_clr;

  // The pending beacon is consumed in the START cycle of a beacon frame.
  assign beacon_clr = (state == ST_START) && (o_tx_kind == KIND_BEACON);

  beacon_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_beacon_timer (
    .clk     (clk),
    .reset   (reset),
    .enable  (i_enable),
    .period  (i_period),
    .clear   (beacon_clr),
    .pending (beacon_pend),
    .overrun (o_overrun)
  );

  // Scheduler FSM with registered outputs; beacons take priority over data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      o_grant    <= 1'b0;
      o_tx_start <= 1'b0;
      o_tx_kind  <= KIND_BEACON;
      o_busy     <= 1'b0;
      o_seq      <= '0;
      o_timeout  <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_grant    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_enable && beacon_pend) begin
            state      <= ST_START;
            o_tx_start <= 1'b1;
            o_tx_kind  <= KIND_BEACON;
            o_busy     <= 1'b1;
          end else if (i_enable && i_req) begin
            state      <= ST_START;
            o_tx_start <= 1'b1;
            o_tx_kind  <= KIND_DATA;
            o_grant    <= 1'b1;
            o_busy     <= 1'b1;
          end
        end
        ST_START: begin
          // Frame-end from tx_loop is not looked at in this cycle.
          state <= ST_WAIT;
          cnt   <= '0;
          if (o_tx_kind == KIND_BEACON) begin
            o_seq <= o_seq + SEQ_ONE;
          end
        end
        ST_WAIT: begin
          if (i_tx_ind) begin
            state <= ST_GAP;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            o_timeout <= 1'b1;
            state     <= ST_GAP;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_GAP: begin
          if (cnt == GUARD_LAST) begin
            state     <= ST_IDLE;
            o_busy    <= 1'b0;
            o_tx_kind <= KIND_BEACON;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
